spi_coeff_master: RTL and testbench

SPI master transmitter that drives the FIR engine's coefficient SPI port (cs, spiClk, mosi) from a parallel word stream. Each frame holds one or more DataWidth-bit words, shifted MSB first, in SPI mode 0 (CPOL=0, CPHA=0). Words enter through a valid/ready handshake with a one-word holding buffer, so consecutive words shift out with no gap. The block is used in on-chip self-load and bench harnesses to load coefficient sets, e.g. 13 taps of 8 bits in one frame.

---
 rtl/spi_coeff_master.sv | 188 ++++++++++++++++++
 tb/tb_spi_coeff_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_coeff_master.sv
// SPI mode-0 master transmitter: streams DataWidth-bit words MSB first, one frame per
// wordLast-terminated burst, with a one-word buffer so back-to-back words shift gap-free.
module spi_coeff_master #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned HalfPeriod = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] wordData,
    input  logic                 wordValid,
    input  logic                 wordLast,
    output logic                 wordReady,
    output logic                 spiClk,
    output logic                 mosi,
    output logic                 cs,
    output logic                 busy
);
    localparam int unsigned DivW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
    localparam int unsigned BitW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(HalfPeriod - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DataWidth - 1);

    typedef enum logic [2:0] {StIdle, StShift, StStall, StHold, StGap} state_e;

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [DataWidth-1:0] buf_q, buf_d;
    logic                 buf_valid_q, buf_valid_d;
    logic                 buf_last_q, buf_last_d;
    logic                 cur_last_q, cur_last_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 load_en;
    logic [DataWidth-1:0] load_word;
    logic                 load_last;

    assign accept = wordValid && ready_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        buf_last_d  = buf_last_q;
        cur_last_d  = cur_last_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        load_en     = 1'b0;
        load_word   = wordData;
        load_last   = wordLast;

        unique case (state_q)
            StIdle: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                load_en = accept;
            end
            StShift: begin
                if (accept) begin
                    buf_d       = wordData;
                    buf_valid_d = 1'b1;
                    buf_last_d  = wordLast;
                end
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != BitLast) begin
                            bit_d   = bit_q + BitW'(1);
                            mosi_d  = shift_q[DataWidth-1];
                            shift_d = shift_q << 1;
                        end else begin
                            bit_d = '0;
                            // A word arriving on the word-end cycle bypasses the buffer.
                            if (buf_valid_q) begin
                                load_en     = 1'b1;
                                load_word   = buf_q;
                                load_last   = buf_last_q;
                                buf_valid_d = 1'b0;
                                buf_last_d  = 1'b0;
                            end else if (accept) begin
                                load_en     = 1'b1;
                                buf_valid_d = 1'b0;
                                buf_last_d  = 1'b0;
                            end else if (cur_last_q) begin
                                state_d = StHold;
                            end else begin
                                state_d = StStall;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StStall: begin
                load_en = accept;
            end
            StHold: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    state_d = StGap;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StGap: begin
                if (div_q == DivLast) begin
                    div_d      = '0;
                    mosi_d     = 1'b0;
                    cur_last_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_en) begin
            shift_d    = load_word << 1;
            mosi_d     = load_word[DataWidth-1];
            cur_last_d = load_last;
            cs_d       = 1'b0;
            div_d      = '0;
            bit_d      = '0;
            state_d    = StShift;
        end

        ready_d = (state_d == StIdle) ||
                  (((state_d == StShift) || (state_d == StStall)) &&
                   !buf_valid_d && !cur_last_d && !buf_last_d);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_last_q  <= 1'b0;
            cur_last_q  <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            buf_last_q  <= buf_last_d;
            cur_last_q  <= cur_last_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign wordReady = ready_q;
    assign spiClk    = sclk_q;
    assign mosi      = mosi_q;
    assign cs        = cs_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_coeff_master.sv
// Bench for spi_coeff_master: an SPI receiver model decodes words on spiClk rises and
// checks them against the words handed over, plus frame timing derived from H and DataWidth.
module tb_spi_coeff_master;
    localparam int DW = 8;
    localparam int HA = 2;
    localparam int HB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, b_valid, b_last;
    logic       a_ready, a_sclk, a_mosi, a_cs, a_busy;
    logic       b_ready, b_sclk, b_mosi, b_cs, b_busy;

    spi_coeff_master #(.DataWidth(DW), .HalfPeriod(HA)) dut_a (
        .clk(clk), .reset(reset), .wordData(a_data), .wordValid(a_valid), .wordLast(a_last),
        .wordReady(a_ready), .spiClk(a_sclk), .mosi(a_mosi), .cs(a_cs), .busy(a_busy)
    );

    spi_coeff_master #(.DataWidth(DW), .HalfPeriod(HB)) dut_b (
        .clk(clk), .reset(reset), .wordData(b_data), .wordValid(b_valid), .wordLast(b_last),
        .wordReady(b_ready), .spiClk(b_sclk), .mosi(b_mosi), .cs(b_cs), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    // receiver model state for dut_a
    logic       cs_prev = 1'b1, sclk_prev = 1'b0;
    logic [7:0] acc = '0;
    bit         rise_a = 1'b0;
    int nb = 0, rx_count = 0, frame_done = 0, fr_start = 0, fr_rises = 0;
    int fr_len = 0, fr_tail = 0, last_rise = -1, sp_min = 0, sp_max = 0, viol = 0;
    // receiver model state for dut_b
    logic b_sclk_prev = 1'b0;
    int b_rises = 0, b_ones = 0, b_cs_low = 0, b_last_rise = -1, b_sp_min = 0, b_sp_max = 0;

    typedef struct {
        logic [7:0] data;
        int first_rise;
        int cs_low;
        int busy_len;
        int ready_back;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_a();
        int sp;
        rise_a = 1'b0;
        if (cs_prev && !a_cs) begin
            fr_start = cyc; fr_rises = 0; sp_min = 1000; sp_max = 0; last_rise = -1;
        end
        if (!a_cs && a_sclk && !sclk_prev) begin
            rise_a = 1'b1;
            if (last_rise >= 0) begin
                sp = cyc - last_rise;
                if (sp < sp_min) sp_min = sp;
                if (sp > sp_max) sp_max = sp;
            end
            last_rise = cyc;
            fr_rises++;
            acc = {acc[6:0], a_mosi};
            nb++;
            if (nb == DW) begin
                nb = 0;
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_word: got %0h expected no word", acc);
                end else begin
                    chk("rx_word", int'(acc), int'(exp_q.pop_front()));
                end
            end
        end
        if (!cs_prev && a_cs) begin
            frame_done++;
            fr_len  = cyc - fr_start;
            fr_tail = cyc - last_rise;
        end
        if (a_cs && a_sclk) viol++;
        cs_prev = a_cs;
        sclk_prev = a_sclk;
    endtask

    task automatic mon_b();
        int sp;
        if (!b_cs) b_cs_low++;
        if (!b_cs && b_sclk && !b_sclk_prev) begin
            b_rises++;
            if (b_mosi) b_ones++;
            if (b_last_rise >= 0) begin
                sp = cyc - b_last_rise;
                if (sp < b_sp_min) b_sp_min = sp;
                if (sp > b_sp_max) b_sp_max = sp;
            end
            b_last_rise = cyc;
        end
        b_sclk_prev = b_sclk;
    endtask

    task automatic step();
        logic       acc_e, rst_e;
        logic [7:0] d;
        acc_e = a_valid && a_ready;
        rst_e = reset;
        d = a_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_e) begin
            exp_q.delete();
            nb = 0;
            rise_a = 1'b0;
            cs_prev = a_cs;
            sclk_prev = a_sclk;
            b_sclk_prev = b_sclk;
        end else begin
            if (acc_e) exp_q.push_back(d);
            mon_a();
            mon_b();
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic l, input int gap);
        a_valid = 1'b0;
        repeat (gap) step();
        a_data = d;
        a_last = l;
        a_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (a_ready) begin
                step();
                a_valid = 1'b0;
                return;
            end
            step();
        end
        a_valid = 1'b0;
        checks++; errors++;
        $display("FAIL accept_timeout: word %0h got no accept, expected accept within 400", d);
    endtask

    task automatic wait_frame(input string name, input int nwords);
        int start;
        int k;
        start = frame_done;
        k = 0;
        while (frame_done == start && k < 2000) begin
            step();
            k++;
        end
        if (frame_done == start) begin
            checks++; errors++;
            $display("FAIL %s_frame_timeout: got no cs release, expected one within 2000", name);
        end else begin
            chk({name, "_rises"}, fr_rises, DW * nwords);
            chk({name, "_cs_tail"}, fr_tail, 2 * HA);
        end
        k = 0;
        while (a_busy && k < 50) begin
            step();
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int base, cl, bl, rb, fr, k, s, bad, n, gap;

        vecs[0] = '{8'hA5, 3, 34, 36, 37};
        vecs[1] = '{8'h00, 3, 34, 36, 37};
        vecs[2] = '{8'hFF, 3, 34, 36, 37};
        vecs[3] = '{8'h3C, 3, 34, 36, 37};
        vecs[4] = '{8'h81, 3, 34, 36, 37};

        reset = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_data = '0;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0;
        repeat (3) step();
        chk("rst_cs", int'(a_cs), 1);
        chk("rst_sclk", int'(a_sclk), 0);
        chk("rst_mosi", int'(a_mosi), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_ready", int'(a_ready), 1);
        chk("rst_b_cs", int'(b_cs), 1);
        reset = 1'b0;
        step();

        // single-word frames: timing offsets relative to the accept cycle
        foreach (vecs[i]) begin
            base = rx_count;
            a_data = vecs[i].data; a_last = 1'b1; a_valid = 1'b1;
            chk("tbl_ready_idle", int'(a_ready), 1);
            step();
            a_valid = 1'b0;
            cl = 0; bl = 0; rb = -1; fr = -1;
            for (int j = 1; j <= 45; j++) begin
                if (!a_cs) cl++;
                if (a_busy) bl++;
                if (a_ready && rb < 0) rb = j;
                if (rise_a && fr < 0) fr = j;
                step();
            end
            chk("tbl_first_rise", fr, vecs[i].first_rise);
            chk("tbl_cs_low", cl, vecs[i].cs_low);
            chk("tbl_busy", bl, vecs[i].busy_len);
            chk("tbl_ready_back", rb, vecs[i].ready_back);
            chk("tbl_rises", fr_rises, DW);
            chk("tbl_spacing_min", sp_min, 2 * HA);
            chk("tbl_spacing_max", sp_max, 2 * HA);
            chk("tbl_words", rx_count - base, 1);
        end

        // 13-word burst with valid held high
        base = rx_count;
        for (int i = 0; i < 13; i++) send_word(8'(i + 1), i == 12, 0);
        wait_frame("burst", 13);
        chk("burst_spacing_min", sp_min, 2 * HA);
        chk("burst_spacing_max", sp_max, 2 * HA);
        chk("burst_words", rx_count - base, 13);

        // stall between two words of one frame
        base = rx_count;
        send_word(8'h5A, 1'b0, 0);
        k = 0;
        while (rx_count == base && k < 200) begin step(); k++; end
        repeat (HA) step();
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            if (a_cs || a_sclk) bad++;
            step();
        end
        chk("stall_lines", bad, 0);
        chk("stall_ready", int'(a_ready), 1);
        a_data = 8'hC3; a_last = 1'b1; a_valid = 1'b1;
        s = cyc;
        step();
        a_valid = 1'b0;
        k = 0;
        while (!rise_a && k < 20) begin step(); k++; end
        chk("stall_first_rise", cyc - s, 1 + HA);
        wait_frame("stall", 2);
        chk("stall_words", rx_count - base, 2);

        // reset during bit 4
        send_word(8'hA5, 1'b1, 0);
        k = 0;
        while (nb != 5 && k < 100) begin step(); k++; end
        reset = 1'b1;
        step();
        chk("midrst_cs", int'(a_cs), 1);
        chk("midrst_sclk", int'(a_sclk), 0);
        chk("midrst_mosi", int'(a_mosi), 0);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_ready", int'(a_ready), 1);
        reset = 1'b0;
        base = rx_count;
        send_word(8'h3C, 1'b1, 1);
        wait_frame("post_reset", 1);
        chk("post_reset_words", rx_count - base, 1);

        // word presented during HOLD/GAP waits for IDLE
        base = rx_count;
        send_word(8'h96, 1'b1, 0);
        k = 0;
        while (rx_count == base && k < 200) begin step(); k++; end
        k = 0;
        while (a_sclk && k < 10) begin step(); k++; end
        a_data = 8'h69; a_last = 1'b1; a_valid = 1'b1;
        bad = 0; k = 0;
        while (a_busy && k < 20) begin
            if (a_ready) bad++;
            step();
            k++;
        end
        chk("holdgap_ready", bad, 0);
        chk("holdgap_not_taken", exp_q.size(), 0);
        chk("idle_ready", int'(a_ready), 1);
        step();
        a_valid = 1'b0;
        chk("idle_taken", exp_q.size(), 1);
        wait_frame("requeue", 1);
        chk("requeue_words", rx_count - base, 2);

        // H=1 instance: 0xFF last word
        b_rises = 0; b_ones = 0; b_cs_low = 0; b_last_rise = -1;
        b_sp_min = 1000; b_sp_max = 0;
        b_data = 8'hFF; b_last = 1'b1; b_valid = 1'b1;
        chk("h1_ready_idle", int'(b_ready), 1);
        step();
        b_valid = 1'b0;
        repeat (30) step();
        chk("h1_rises", b_rises, DW);
        chk("h1_ones", b_ones, DW);
        chk("h1_cs_low", b_cs_low, 2 * HB * DW + HB);
        chk("h1_spacing_min", b_sp_min, 2 * HB);
        chk("h1_spacing_max", b_sp_max, 2 * HB);

        // randomized frames, gaps occasionally long enough to stall
        for (int f = 0; f < 10; f++) begin
            n = int'($urandom_range(1, 4));
            base = rx_count;
            for (int w = 0; w < n; w++) begin
                gap = ($urandom_range(0, 4) == 0) ? 12 : int'($urandom_range(0, 2));
                send_word(8'($urandom), w == n - 1, gap);
            end
            wait_frame("rand", n);
            chk("rand_words", rx_count - base, n);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("cs_high_sclk_low", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
